// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 UART transmitter, LSB first
module uart_tx_fifo #(
   parameter int CLK_PER_BIT = 868,
   parameter int DEPTH_LOG2  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  send_valid,
   input  logic [7:0]            send_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  busy,
   output logic                  overflow,
   output logic                  txd
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2 + 1;
   localparam int CNT_W = $clog2(CLK_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t              state_q, state_n;
   logic [7:0]          mem [DEPTH];
   logic [PW-1:0]       wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
   logic [CNT_W-1:0]    baud_cnt, baud_cnt_n;
   logic [2:0]          bit_idx, bit_idx_n;
   logic [7:0]          shift_q, shift_n;
   logic [7:0]          head;
   logic                txd_n;
   logic                push, pop, bit_end;

   // full is the pre-edge flag, so a write while full is dropped even if a pop coincides
   assign push     = send_valid & ~full;
   assign head     = mem[rd_ptr[DEPTH_LOG2-1:0]];
   assign bit_end  = (baud_cnt == BIT_LAST);
   assign wr_ptr_n = wr_ptr + PW'(push);
   assign rd_ptr_n = rd_ptr + PW'(pop);

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[DEPTH_LOG2-1:0]] <= send_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr_n;
         rd_ptr <= rd_ptr_n;
         count  <= wr_ptr_n - rd_ptr_n;
         full   <= (wr_ptr_n[PW-1] != rd_ptr_n[PW-1]) &&
                   (wr_ptr_n[DEPTH_LOG2-1:0] == rd_ptr_n[DEPTH_LOG2-1:0]);
         empty  <= (wr_ptr_n == rd_ptr_n);
         if (send_valid && full)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift_q  <= '0;
         txd      <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_n;
         baud_cnt <= baud_cnt_n;
         bit_idx  <= bit_idx_n;
         shift_q  <= shift_n;
         txd      <= txd_n;
         busy     <= (state_n != IDLE);
      end
   end

   always_comb begin
      state_n    = state_q;
      baud_cnt_n = baud_cnt;
      bit_idx_n  = bit_idx;
      shift_n    = shift_q;
      txd_n      = txd;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            txd_n = 1'b1;
            if (!empty) begin
               pop        = 1'b1;
               shift_n    = head;
               baud_cnt_n = '0;
               txd_n      = 1'b0;
               state_n    = START;
            end
         end
         START: begin
            if (bit_end) begin
               baud_cnt_n = '0;
               bit_idx_n  = '0;
               txd_n      = shift_q[0];
               state_n    = DATA;
            end else begin
               baud_cnt_n = baud_cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_cnt_n = '0;
               if (bit_idx == 3'd7) begin
                  txd_n   = 1'b1;
                  state_n = STOP;
               end else begin
                  shift_n   = shift_q >> 1;
                  txd_n     = shift_q[1];
                  bit_idx_n = bit_idx + 3'd1;
               end
            end else begin
               baud_cnt_n = baud_cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_cnt_n = '0;
               // chain straight into the next start bit when more data is queued
               if (!empty) begin
                  pop     = 1'b1;
                  shift_n = head;
                  txd_n   = 1'b0;
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               baud_cnt_n = baud_cnt + CNT_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            txd_n   = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic       send_valid;
   logic [7:0] send_data;
   logic       full, empty, busy, overflow, txd;
   logic [2:0] count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   uart_tx_fifo #(.CLK_PER_BIT(4), .DEPTH_LOG2(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .send_valid (send_valid),
      .send_data  (send_data),
      .full       (full),
      .empty      (empty),
      .count      (count),
      .busy       (busy),
      .overflow   (overflow),
      .txd        (txd)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      send_valid = 1'b1;
      send_data  = d;
      tick;
      send_valid = 1'b0;
   endtask

   // lead = cycles already elapsed since the edge that dropped txd
   task automatic recv_frame(input int lead_in, output logic [7:0] d, output int gap);
      int lead;
      lead = lead_in;
      gap  = 0;
      d    = '0;
      while (txd !== 1'b0 && gap < 200) begin
         tick;
         gap++;
      end
      check("frame_seen", 32'(gap < 200), 32'd1);
      if (gap > 0) lead = 0;
      repeat (2 - lead) tick;
      check("start_bit", 32'(txd), 32'd0);
      for (int i = 0; i < 8; i++) begin
         repeat (4) tick;
         d[i] = txd;
      end
      repeat (4) tick;
      check("stop_bit", 32'(txd), 32'd1);
      tick;
      check("busy_in_stop", 32'(busy), 32'd1);
      tick;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] d;
      int         g;
      int         lows;

      rst        = 1'b1;
      send_valid = 1'b0;
      send_data  = 8'h00;
      repeat (2) tick;
      rst = 1'b0;
      tick;
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_count", 32'(count), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);

      // single byte: latency and exact 40-cycle frame
      push(8'h55);
      check("lat_txd_pre", 32'(txd), 32'd1);
      check("lat_count_pre", 32'(count), 32'd1);
      check("lat_busy_pre", 32'(busy), 32'd0);
      tick;
      check("lat_txd_fall", 32'(txd), 32'd0);
      check("lat_busy", 32'(busy), 32'd1);
      check("lat_count_pop", 32'(count), 32'd0);
      recv_frame(0, d, g);
      check("f55_data", 32'(d), 32'h55);
      check("f55_busy_end", 32'(busy), 32'd0);
      check("f55_txd_end", 32'(txd), 32'd1);

      // three consecutive pushes, back-to-back frames
      send_valid = 1'b1;
      send_data  = 8'h41;
      tick;
      check("b2b_count1", 32'(count), 32'd1);
      send_data = 8'h42;
      tick;
      check("b2b_count2", 32'(count), 32'd1);
      send_data = 8'h43;
      tick;
      send_valid = 1'b0;
      check("b2b_count_peak", 32'(count), 32'd2);
      recv_frame(1, d, g);
      check("b2b_d0", 32'(d), 32'h41);
      recv_frame(0, d, g);
      check("b2b_gap1", 32'(g), 32'd0);
      check("b2b_d1", 32'(d), 32'h42);
      recv_frame(0, d, g);
      check("b2b_gap2", 32'(g), 32'd0);
      check("b2b_d2", 32'(d), 32'h43);
      check("b2b_busy_end", 32'(busy), 32'd0);
      check("b2b_empty_end", 32'(empty), 32'd1);

      // fill depth-4 FIFO during a frame, 5th push dropped
      push(8'h10);
      fork
         recv_frame(0, d, g);
         begin
            repeat (3) tick;
            send_valid = 1'b1;
            for (int i = 0; i < 5; i++) begin
               send_data = 8'(17 + i);
               tick;
               if (i == 3) begin
                  check("ovf_full4", 32'(full), 32'd1);
                  check("ovf_ovf_before", 32'(overflow), 32'd0);
               end
            end
            send_valid = 1'b0;
            check("ovf_flag", 32'(overflow), 32'd1);
            check("ovf_count", 32'(count), 32'd4);
         end
      join
      check("ovf_d_first", 32'(d), 32'h10);
      for (int k = 0; k < 4; k++) begin
         recv_frame(0, d, g);
         check("ovf_gap", 32'(g), 32'd0);
         check("ovf_data", 32'(d), 32'(17 + k));
      end
      lows = 0;
      for (int i = 0; i < 50; i++) begin
         if (txd === 1'b0) lows++;
         tick;
      end
      check("ovf_no_extra_frame", 32'(lows), 32'd0);
      check("ovf_sticky", 32'(overflow), 32'd1);
      check("ovf_empty_end", 32'(empty), 32'd1);

      // push on the same edge STOP pops with count=1
      push(8'h20);
      push(8'h21);
      check("pp_count_pre", 32'(count), 32'd1);
      fork
         recv_frame(0, d, g);
         begin
            repeat (39) tick;
            send_valid = 1'b1;
            send_data  = 8'h22;
            tick;
            send_valid = 1'b0;
            check("pp_count_same", 32'(count), 32'd1);
         end
      join
      check("pp_d0", 32'(d), 32'h20);
      recv_frame(0, d, g);
      check("pp_gap1", 32'(g), 32'd0);
      check("pp_d1", 32'(d), 32'h21);
      recv_frame(0, d, g);
      check("pp_gap2", 32'(g), 32'd0);
      check("pp_d2", 32'(d), 32'h22);
      check("pp_empty_end", 32'(empty), 32'd1);

      // asynchronous reset mid-DATA with bytes queued
      push(8'hA5);
      send_valid = 1'b1;
      send_data  = 8'hB1;
      tick;
      send_data = 8'hB2;
      tick;
      send_data = 8'hB3;
      tick;
      send_valid = 1'b0;
      check("ar_count_pre", 32'(count), 32'd3);
      repeat (13) tick;
      check("ar_busy_pre", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("ar_txd", 32'(txd), 32'd1);
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_count", 32'(count), 32'd0);
      check("ar_overflow", 32'(overflow), 32'd0);
      check("ar_empty", 32'(empty), 32'd1);
      tick;
      rst = 1'b0;
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         if (txd === 1'b0) lows++;
         tick;
      end
      check("ar_silent", 32'(lows), 32'd0);
      check("ar_busy_after", 32'(busy), 32'd0);

      // all-zero and all-one data bytes
      push(8'h00);
      push(8'hFF);
      recv_frame(0, d, g);
      check("d00_data", 32'(d), 32'h00);
      recv_frame(0, d, g);
      check("dff_gap", 32'(g), 32'd0);
      check("dff_data", 32'(d), 32'hFF);
      check("dff_busy_end", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered UART transmitter serving the core's send handshake. The decode stage pulses send_valid with a byte; this block queues the byte in a small FIFO and serializes it on txd as 8N1, LSB first. It sits between the core's uart_send_ready/uart_send_data outputs and the board TX pin, so the core never waits on a frame in flight unless the FIFO is full.

Parameters:
CLK_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200 baud); legal range >= 2
DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
send_valid  input  1  enqueue request (driven by core uart_send_ready), sampled each edge
send_data  input  8  byte to enqueue (core uart_send_data), sampled with send_valid
full  output  1  FIFO holds 2^DEPTH_LOG2 entries; core must not enqueue
empty  output  1  FIFO holds 0 entries
count  output  DEPTH_LOG2+1  current FIFO occupancy
busy  output  1  serializer not in IDLE
overflow  output  1  sticky: an enqueue was attempted while full
txd  output  1  serial line, idle high

Behaviour:
- Clock/reset: one clock, clk; rst asynchronous, active-high. All outputs registered.
- Reset values: txd=1, busy=0, full=0, empty=1, count=0, overflow=0; FSM=IDLE, baud counter=0, bit index=0, FIFO read/write pointers=0. Reset asserted mid-frame aborts the frame immediately: txd=1 and the FIFO contents are discarded.
- Enqueue: each edge with send_valid=1 and full=0 writes send_data at wr_ptr, wr_ptr+1 mod depth. A held send_valid enqueues once per cycle (the producer pulses). send_valid=1 with full=1: byte dropped, overflow set to 1 and held until rst. full uses pre-edge occupancy, so a write while full is dropped even if a pop occurs on the same edge.
- Dequeue: the FSM pops in IDLE when empty=0; rd_ptr+1 mod depth. Simultaneous push and pop leave count unchanged. Pointers are DEPTH_LOG2+1 bits; full/empty come from MSB compare.
- FSM states IDLE, START, DATA, STOP:
  IDLE: txd=1, busy=0. If empty=0: latch head byte into shift reg, pop, baud_cnt=0, txd<=0, go START.
  START: txd=0 for CLK_PER_BIT cycles, then txd<=shift[0], bit_idx=0, go DATA.
  DATA: each bit held CLK_PER_BIT cycles; at bit end shift right, bit_idx+1; after bit_idx=7 completes txd<=1, go STOP.
  STOP: txd=1 for CLK_PER_BIT cycles; at end, if empty=0 pop and start the next START directly (no idle gap), else go IDLE.
- Baud counter counts 0..CLK_PER_BIT-1 and resets at each bit boundary; frame length is exactly 10*CLK_PER_BIT cycles.
- Latency: byte enqueued on edge t into an empty, idle block: txd falls after edge t+1 (FSM sees empty=0 on edge t+1).
- busy=1 from START entry until return to IDLE; continuous across back-to-back frames.
- count wraps never: saturates logically at 2^DEPTH_LOG2 by the drop rule; an 8-bit byte 0x00 or 0xFF needs no special handling.

Test Plan:
- CLK_PER_BIT=4: reset, pulse send_valid with 0x55 -> txd low after the next edge, then bits 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles; frame 40 cycles; busy drops back to 0 afterwards.
- Enqueue 0x41,0x42,0x43 on 3 consecutive cycles -> count peaks at 2 (first popped), three frames back-to-back, 120 cycles total, txd never idles between frames, empty=1 at end.
- DEPTH_LOG2=2: with serializer busy, push 5 bytes while the first frame is on the line -> full=1 after 4 queued, 5th dropped, overflow=1; exactly 5 frames total go out (1 in flight + 4), data order preserved.
- Push on the same edge the STOP state pops with count=1 -> count stays 1, no byte lost or duplicated.
- Assert rst mid-DATA of 0xA5 with 3 queued bytes -> txd=1, busy=0, count=0, overflow=0 immediately (async); after release, no frame is sent until a new push.
- Byte 0x00 and 0xFF -> 8 data bits all 0 / all 1, start=0 and stop=1 still present.
